// File: rtl/serial_tx_ctrl_if.sv
// FIFO read port between the 16x9 serial FIFO and the TX sequencer.
// master is the sequencer side, slave is the FIFO side.
interface serial_tx_ctrl_if #(
  parameter int DATA_W = 9
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_request;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_request
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_request
  );
endinterface

// File: rtl/serial_tx_ctrl.sv
// Serial TX sequencer: pops FIFO words and frames them onto tx
// with start/data/parity/stop bits timed by a 24.8 baud divisor.
module serial_tx_ctrl #(
  parameter int DATA_W = 9,
  parameter int FRAC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      control,
  input  logic [31:0]      brd,
  serial_tx_ctrl_if.master fifo,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);
  localparam int IW = 32 - FRAC_W;
  localparam int CW = IW + 1;
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [BW-1:0]     nb_q, nb_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] f_q, f_d;
  logic [IW-1:0]     i_q, i_d;
  logic [1:0]        pm_q, pm_d;
  logic              st2_q, st2_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              new_bit;
  logic [FRAC_W:0]   acc_sum;
  logic [IW-1:0]     i_eff;
  logic              unused_ctl;

  assign unused_ctl = ^control[31:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      nb_q    <= '0;
      cyc_q   <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      i_q     <= '0;
      pm_q    <= '0;
      st2_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      nb_q    <= nb_d;
      cyc_q   <= cyc_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      i_q     <= i_d;
      pm_q    <= pm_d;
      st2_q   <= st2_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    nb_d    = nb_q;
    acc_d   = acc_q;
    f_d     = f_q;
    i_d     = i_q;
    pm_d    = pm_q;
    st2_d   = st2_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    req_d   = 1'b0;
    new_bit = 1'b0;
    cyc_d   = (cyc_q == '0) ? '0 : cyc_q - CW'(1);
    acc_sum = {1'b0, acc_q} + {1'b0, f_q};
    i_eff   = (i_q == '0) ? IW'(1) : i_q;

    unique case (state_q)
      S_IDLE: begin
        tx_d = ~control[7];
        if (control[0] && !control[7] && !fifo.fifo_empty) begin
          state_d = S_POP;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          tx_d    = 1'b1;
          sh_d    = fifo.fifo_rd_data;
          nb_d    = (control[3:1] > 3'd4) ? BW'(8)
                  : BW'(control[3:1]) + BW'(5);
          pm_d    = control[5:4];
          st2_d   = control[6];
          i_d     = brd[31:FRAC_W];
          f_d     = brd[FRAC_W-1:0];
          acc_d   = '0;
          par_d   = 1'b0;
          cyc_d   = '0;
        end
      end
      S_POP: begin
        state_d = S_START;
        tx_d    = 1'b0;
        new_bit = 1'b1;
      end
      S_START: begin
        if (cyc_q == '0) begin
          state_d = S_DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          par_d   = par_q ^ sh_q[0];
          bit_d   = nb_q - BW'(1);
          new_bit = 1'b1;
        end
      end
      S_DATA: begin
        if (cyc_q == '0) begin
          new_bit = 1'b1;
          if (bit_q != '0) begin
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
            par_d = par_q ^ sh_q[0];
            bit_d = bit_q - BW'(1);
          end else if (pm_q != 2'b00) begin
            state_d = S_PAR;
            // 01 even, 10 odd, 11 mark
            tx_d    = pm_q[1] ? (pm_q[0] | ~par_q) : par_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
            bit_d   = BW'(st2_q);
          end
        end
      end
      S_PAR: begin
        if (cyc_q == '0) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = BW'(st2_q);
          new_bit = 1'b1;
        end
      end
      S_STOP: begin
        if (cyc_q == '0) begin
          if (bit_q != '0) begin
            bit_d   = '0;
            new_bit = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            tx_d    = ~control[7];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // fractional carry stretches this bit by one cycle
    if (new_bit) begin
      acc_d = acc_sum[FRAC_W-1:0];
      cyc_d = CW'(i_eff) + CW'(acc_sum[FRAC_W]) - CW'(1);
    end

    done_d = (state_d == S_STOP) && (cyc_d == '0) && (bit_d == '0);
  end

  assign tx                   = tx_q;
  assign busy                 = busy_q;
  assign frame_done           = done_q;
  assign fifo.fifo_rd_request = req_q;
endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl: FIFO model plus a
// bit-list/period reference model of each transmitted frame.
module tb_serial_tx_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] control;
  logic [31:0] brd;
  logic        tx;
  logic        busy;
  logic        frame_done;

  serial_tx_ctrl_if #(.DATA_W(9)) fif ();

  serial_tx_ctrl #(.DATA_W(9), .FRAC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .control   (control),
    .brd       (brd),
    .fifo      (fif),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   errors   = 0;
  int   pops     = 0;
  int   busy_bad = 0;
  int   gap_low  = 0;
  bit   exp_q[$];
  bit   obs_q[$];
  logic [8:0] fq[$];

  // FIFO pops at the end of the request cycle
  always @(negedge clk) begin
    if (fif.fifo_rd_request === 1'b1) begin
      pops++;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    fif.fifo_empty   = (fq.size() == 0);
    fif.fifo_rd_data = (fq.size() > 0) ? fq[0] : 9'h0;
  end

  task automatic push(input logic [8:0] w);
    fq.push_back(w);
    fif.fifo_empty   = 1'b0;
    fif.fifo_rd_data = fq[0];
  endtask

  task automatic build_exp(input logic [8:0] w, input logic [31:0] c,
                           input logic [31:0] b);
    bit bits[$];
    int n, ip, fr, acc, per, wl;
    bit p;
    wl = int'(c[3:1]);
    n  = (wl <= 4) ? wl + 5 : 8;
    p  = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(w[i]);
      p ^= w[i];
    end
    case (c[5:4])
      2'b01: bits.push_back(p);
      2'b10: bits.push_back(!p);
      2'b11: bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (c[6]) bits.push_back(1'b1);
    ip  = int'(b[31:8]);
    if (ip == 0) ip = 1;
    fr  = int'(b[7:0]);
    acc = 0;
    exp_q.delete();
    foreach (bits[k]) begin
      acc += fr;
      per  = ip;
      if (acc >= 256) begin
        per++;
        acc -= 256;
      end
      repeat (per) exp_q.push_back(bits[k]);
    end
  endtask

  function automatic int frame_diffs();
    int d = 0;
    if (obs_q.size() != exp_q.size()) d++;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      if (obs_q[k] != exp_q[k]) d++;
    return d;
  endfunction

  task automatic run_frame(input int mode, output bit popped,
                           output int wc, output bit done);
    popped = 1'b0;
    wc     = 0;
    done   = 1'b0;
    gap_low = 0;
    obs_q.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      wc++;
      if (fif.fifo_rd_request === 1'b1) begin
        popped = 1'b1;
        break;
      end
      if (tx !== 1'b1) gap_low++;
    end
    if (popped) begin
      if (mode == 1) begin
        control = $urandom;
        brd     = $urandom;
      end else if (mode == 2) begin
        control[0] = 1'b0;
      end
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        obs_q.push_back(tx);
        if (busy !== 1'b1) busy_bad++;
        if (frame_done === 1'b1) begin
          done = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx got %b want 1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (fif.fifo_rd_request !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got %b want 0", fif.fifo_rd_request);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", frame_done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_plain();
    bit pd, dn;
    int wc, bad, p0;
    bit lit[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    control  = 32'h7;
    brd      = 32'h400;
    busy_bad = 0;
    p0       = pops;
    push(9'h0A5);
    build_exp(9'h0A5, control, brd);
    run_frame(0, pd, wc, dn);
    checks++;
    if (!(pd && dn)) begin
      errors++; $display("FAIL plain_frame pop %b done %b want 1 1", pd, dn);
    end
    checks++;
    if (obs_q.size() != 40) begin
      errors++; $display("FAIL plain_len got %0d want 40", obs_q.size());
    end
    bad = 0;
    for (int k = 0; k < 40 && k < obs_q.size(); k++)
      if (obs_q[k] != lit[k/4]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL plain_bits got %0d bad cycles want 0", bad);
    end
    checks++;
    if (frame_diffs() != 0) begin
      errors++; $display("FAIL plain_model got %0d diffs want 0", frame_diffs());
    end
    checks++;
    if (busy_bad != 0) begin
      errors++; $display("FAIL plain_busy got %0d low cycles want 0", busy_bad);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL plain_after busy %b tx %b want 0 1", busy, tx);
    end
    checks++;
    if (pops - p0 != 1) begin
      errors++; $display("FAIL plain_pops got %0d want 1", pops - p0);
    end
  endtask

  task automatic test_parity();
    logic [31:0] cl[3] = '{32'h17, 32'h27, 32'h77};
    int          ln[3] = '{44, 44, 48};
    bit          pb[3] = '{1'b0, 1'b1, 1'b1};
    bit pd, dn;
    int wc;
    brd = 32'h400;
    for (int t = 0; t < 3; t++) begin
      control = cl[t];
      push(9'h0A5);
      build_exp(9'h0A5, control, brd);
      run_frame(0, pd, wc, dn);
      checks++;
      if (!(pd && dn)) begin
        errors++; $display("FAIL par%0d_frame pop %b done %b want 1 1", t, pd, dn);
      end
      checks++;
      if (obs_q.size() != ln[t]) begin
        errors++;
        $display("FAIL par%0d_len got %0d want %0d", t, obs_q.size(), ln[t]);
      end
      checks++;
      if (obs_q.size() <= 36 || obs_q[36] != pb[t]) begin
        errors++;
        $display("FAIL par%0d_bit got %b want %b", t,
                 (obs_q.size() > 36) ? obs_q[36] : 1'bx, pb[t]);
      end
      checks++;
      if (frame_diffs() != 0) begin
        errors++; $display("FAIL par%0d_model got %0d diffs want 0", t, frame_diffs());
      end
    end
    control = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_frac();
    bit pd, dn;
    int wc;
    logic [8:0] w;
    w       = 9'($urandom);
    control = 32'h7;
    brd     = 32'h380;
    push(w);
    build_exp(w, control, brd);
    run_frame(0, pd, wc, dn);
    checks++;
    if (!(pd && dn) || obs_q.size() != 35) begin
      errors++; $display("FAIL frac_len got %0d want 35", obs_q.size());
    end
    checks++;
    if (frame_diffs() != 0) begin
      errors++; $display("FAIL frac_model got %0d diffs want 0", frame_diffs());
    end
    control = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit pd, dn;
    int wc, p0;
    control = 32'h9;
    brd     = 32'h200;
    p0      = pops;
    push(9'h1FF);
    push(9'h1FF);
    build_exp(9'h1FF, control, brd);
    run_frame(0, pd, wc, dn);
    checks++;
    if (!(pd && dn) || frame_diffs() != 0) begin
      errors++; $display("FAIL b2b_first got %0d diffs want 0", frame_diffs());
    end
    run_frame(0, pd, wc, dn);
    checks++;
    if (wc != 2) begin
      errors++; $display("FAIL b2b_gap got %0d want 2", wc);
    end
    checks++;
    if (gap_low != 0) begin
      errors++; $display("FAIL b2b_gap_tx got %0d low cycles want 0", gap_low);
    end
    checks++;
    if (!(pd && dn) || frame_diffs() != 0) begin
      errors++; $display("FAIL b2b_second got %0d diffs want 0", frame_diffs());
    end
    checks++;
    if (pops - p0 != 2) begin
      errors++; $display("FAIL b2b_pops got %0d want 2", pops - p0);
    end
    control = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_empty_break_disable();
    bit pd, dn;
    int wc, p0, p1;
    control = 32'h7;
    brd     = 32'h200;
    p0      = pops;
    repeat (20) @(negedge clk);
    checks++;
    if (pops != p0 || tx !== 1'b1) begin
      errors++; $display("FAIL empty got pops %0d tx %b want 0 1", pops - p0, tx);
    end
    control = 32'h87;
    push(9'h055);
    repeat (20) @(negedge clk);
    checks++;
    if (pops != p0) begin
      errors++; $display("FAIL break_pops got %0d want 0", pops - p0);
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL break_tx got tx %b busy %b want 0 0", tx, busy);
    end
    control = 32'h7;
    build_exp(9'h055, control, brd);
    run_frame(0, pd, wc, dn);
    checks++;
    if (!(pd && dn) || frame_diffs() != 0) begin
      errors++; $display("FAIL unbreak_frame got %0d diffs want 0", frame_diffs());
    end
    push(9'h133);
    push(9'h0C8);
    build_exp(9'h133, control, brd);
    run_frame(2, pd, wc, dn);
    checks++;
    if (!(pd && dn) || frame_diffs() != 0) begin
      errors++; $display("FAIL disable_frame got %0d diffs want 0", frame_diffs());
    end
    p1 = pops;
    repeat (30) @(negedge clk);
    checks++;
    if (pops != p1 || fq.size() != 1) begin
      errors++;
      $display("FAIL disable_pops got %0d left %0d want 0 1", pops - p1, fq.size());
    end
    control = 32'h7;
    build_exp(9'h0C8, control, brd);
    run_frame(0, pd, wc, dn);
    checks++;
    if (!(pd && dn) || frame_diffs() != 0) begin
      errors++; $display("FAIL reenable_frame got %0d diffs want 0", frame_diffs());
    end
    control = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit pd, dn;
    int wc;
    logic [8:0]  w;
    logic [31:0] c, b;
    for (int it = 0; it < 10; it++) begin
      w = 9'($urandom);
      c = ($urandom & 32'h7E) | 32'h1;
      b = {24'($urandom_range(0, 5)), 8'($urandom_range(0, 255))};
      control = c;
      brd     = b;
      push(w);
      build_exp(w, c, b);
      run_frame(1, pd, wc, dn);
      control = 32'h0;
      checks++;
      if (!(pd && dn)) begin
        errors++; $display("FAIL rnd%0d_frame pop %b done %b want 1 1", it, pd, dn);
      end
      checks++;
      if (frame_diffs() != 0) begin
        errors++;
        $display("FAIL rnd%0d_model ctl %h brd %h got %0d diffs want 0",
                 it, c, b, frame_diffs());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit pd, dn, seen;
    int wc;
    control = 32'h7;
    brd     = 32'h400;
    push(9'h0A5);
    push(9'h06B);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fif.fifo_rd_request === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstmid_pop got 0 want 1");
    end
    repeat (18) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_bit3 got tx %b busy %b want 0 1", tx, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got tx %b busy %b want 1 0", tx, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    build_exp(9'h06B, control, brd);
    run_frame(0, pd, wc, dn);
    checks++;
    if (!(pd && dn)) begin
      errors++; $display("FAIL rstmid_repop pop %b done %b want 1 1", pd, dn);
    end
    checks++;
    if (frame_diffs() != 0) begin
      errors++; $display("FAIL rstmid_frame got %0d diffs want 0", frame_diffs());
    end
  endtask

  initial begin
    reset            = 1'b1;
    control          = 32'h0;
    brd              = 32'h400;
    fif.fifo_empty   = 1'b1;
    fif.fifo_rd_data = 9'h0;
    test_reset();
    test_plain();
    test_parity();
    test_frac();
    test_back_to_back();
    test_empty_break_disable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
